// File: rtl/isp_timing_gen.sv
// Video timing and test-pattern source: free-running raster counters, a run/drain FSM
// and a registered decode stage driving the ISP sync/den/RGB stream.
module isp_timing_gen #(
  parameter int unsigned H_ACTIVE = 512,
  parameter int unsigned V_ACTIVE = 512,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 32,
  parameter int unsigned H_BP     = 32,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 4,
  parameter int unsigned CHK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       out_vsync,
  output logic       out_hsync,
  output logic       out_den,
  output logic [7:0] out_data_R,
  output logic [7:0] out_data_G,
  output logic [7:0] out_data_B,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  // Inclusive bounds keep every constant representable in the counter width.
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hCnt_q, hCnt_d;
  logic [VW-1:0] vCnt_q, vCnt_d;
  logic [1:0]    pat_q, pat_d;

  logic          vsync_q, hsync_q, den_q, fs_q;
  logic [7:0]    r_q, g_q, b_q;

  logic          lastCycle, active, frameHead;
  logic [HW-1:0] hNext;
  logic [VW-1:0] vNext;
  logic [1:0]    patCur;

  logic          denC, hsC, vsC, fsC;
  logic [7:0]    rC, gC, bC;
  logic [2:0]    barIdx;
  logic          chkBit;

  assign lastCycle = (hCnt_q == H_LAST) && (vCnt_q == V_LAST);
  assign active    = (state_q != IDLE);
  assign frameHead = active && (hCnt_q == '0) && (vCnt_q == '0);
  assign patCur    = frameHead ? pattern_sel : pat_q;
  assign hNext     = (hCnt_q == H_LAST) ? '0 : hCnt_q + 1'b1;
  assign vNext     = (hCnt_q != H_LAST) ? vCnt_q :
                     (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hCnt_q  <= '0;
      vCnt_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      hCnt_q  <= hCnt_d;
      vCnt_q  <= vCnt_d;
      pat_q   <= pat_d;
    end
  end

  // A started frame always runs to its last cycle; only there does enable decide.
  always_comb begin
    state_d = state_q;
    hCnt_d  = hCnt_q;
    vCnt_d  = vCnt_q;
    pat_d   = pat_q;
    if (frameHead) pat_d = pattern_sel;
    case (state_q)
      IDLE: begin
        hCnt_d = '0;
        vCnt_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        hCnt_d = hNext;
        vCnt_d = vNext;
        if (!enable) state_d = lastCycle ? IDLE : DRAIN;
      end
      DRAIN: begin
        hCnt_d = hNext;
        vCnt_d = vNext;
        if (enable)         state_d = RUN;
        else if (lastCycle) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        hCnt_d  = '0;
        vCnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    barIdx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hCnt_q >= HW'(k * (H_ACTIVE / 8))) barIdx = barIdx + 3'd1;
    end
  end

  assign chkBit = hCnt_q[CHK_LOG2] ^ vCnt_q[CHK_LOG2];

  // Bar colours follow a bit pattern of the bar index: R=~b1, G=~b2, B=~b0.
  always_comb begin
    denC = active && (hCnt_q <= H_ACT_LAST) && (vCnt_q <= V_ACT_LAST);
    hsC  = active && (hCnt_q >= HS_FIRST) && (hCnt_q <= HS_LAST);
    vsC  = active && (vCnt_q >= VS_FIRST) && (vCnt_q <= VS_LAST);
    fsC  = denC && (hCnt_q == '0) && (vCnt_q == '0);
    rC   = 8'h00;
    gC   = 8'h00;
    bC   = 8'h00;
    if (denC) begin
      case (patCur)
        2'd0: begin
          rC = {8{~barIdx[1]}};
          gC = {8{~barIdx[2]}};
          bC = {8{~barIdx[0]}};
        end
        2'd1: begin
          rC = 8'(hCnt_q);
          gC = 8'(hCnt_q);
          bC = 8'(hCnt_q);
        end
        2'd2: begin
          rC = 8'h80;
          gC = 8'h80;
          bC = 8'h80;
        end
        default: begin
          rC = {8{chkBit}};
          gC = {8{chkBit}};
          bC = {8{chkBit}};
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      den_q   <= 1'b0;
      fs_q    <= 1'b0;
      r_q     <= 8'h00;
      g_q     <= 8'h00;
      b_q     <= 8'h00;
    end else begin
      vsync_q <= vsC;
      hsync_q <= hsC;
      den_q   <= denC;
      fs_q    <= fsC;
      r_q     <= rC;
      g_q     <= gC;
      b_q     <= bC;
    end
  end

  assign out_vsync   = vsync_q;
  assign out_hsync   = hsync_q;
  assign out_den     = den_q;
  assign frame_start = fs_q;
  assign out_data_R  = r_q;
  assign out_data_G  = g_q;
  assign out_data_B  = b_q;

endmodule

// File: tb/tb_isp_timing_gen.sv
// Scoreboard bench for isp_timing_gen: a frame-position reference model queues the
// expected port values per cycle, and a monitor compares them against the DUT.
module tb_isp_timing_gen;

  localparam int HA = 16, VA = 4;
  localparam int HFP = 2, HSW = 3, HBP = 3;
  localparam int VFP = 1, VSW = 1, VBP = 1;
  localparam int CHK = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        den;
    logic        fs;
    logic [23:0] rgb;
  } pix_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       out_vsync, out_hsync, out_den, frame_start;
  logic [7:0] out_data_R, out_data_G, out_data_B;

  isp_timing_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .CHK_LOG2(CHK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pattern_sel(pattern_sel),
    .out_vsync(out_vsync),
    .out_hsync(out_hsync),
    .out_den(out_den),
    .out_data_R(out_data_R),
    .out_data_G(out_data_G),
    .out_data_B(out_data_B),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pix_t expQ[$];
  int   checks;
  int   errors;
  int   cycle;
  bit   started;

  // Reference model: whether a frame is in flight, position within it, latched pattern.
  bit   mActive;
  int   mPos;
  int   mPat;

  function automatic logic [23:0] barRgb(input int idx);
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic pix_t pixelOf(input int pos, input int pat);
    pix_t       p;
    int         h;
    int         v;
    logic [7:0] g;
    h = pos % HT;
    v = pos / HT;
    p = '0;
    p.den = (h < HA) && (v < VA);
    p.hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
    p.vs  = (v >= VA + VFP) && (v < VA + VFP + VSW);
    p.fs  = p.den && (pos == 0);
    if (p.den) begin
      case (pat)
        0: p.rgb = barRgb((h * 8) / HA);
        1: begin
          g = 8'(h % 256);
          p.rgb = {g, g, g};
        end
        2: p.rgb = 24'h808080;
        default: p.rgb = ((((h / (1 << CHK)) + (v / (1 << CHK))) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      endcase
    end
    return p;
  endfunction

  function automatic pix_t dutOut();
    pix_t p;
    p.vs  = out_vsync;
    p.hs  = out_hsync;
    p.den = out_den;
    p.fs  = frame_start;
    p.rgb = {out_data_R, out_data_G, out_data_B};
    return p;
  endfunction

  task automatic checkOutput(input string name, input pix_t act, input pix_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got vs=%b hs=%b den=%b fs=%b rgb=%06h, expected vs=%b hs=%b den=%b fs=%b rgb=%06h",
               name, cycle, act.vs, act.hs, act.den, act.fs, act.rgb,
               exp.vs, exp.hs, exp.den, exp.fs, exp.rgb);
    end
  endtask

  // Drives one clock's inputs at the falling edge and queues what the ports must show after the next rising edge.
  task automatic applyStimulus(input bit en, input logic [1:0] sel, input bit rst);
    pix_t e;
    bit   wasRst;
    @(negedge clk);
    wasRst      = reset;
    enable      = en;
    pattern_sel = sel;
    reset       = rst;
    if (rst && !wasRst) begin
      #1;
      checkOutput("async_reset", dutOut(), '0);
    end
    e = '0;
    if (rst) begin
      mActive = 1'b0;
      mPos    = 0;
      mPat    = 0;
    end else if (!mActive) begin
      if (en) begin
        mActive = 1'b1;
        mPos    = 0;
      end
    end else begin
      if (mPos == 0) mPat = int'(sel);
      e = pixelOf(mPos, mPat);
      if (mPos == FRAME - 1) begin
        if (!en) mActive = 1'b0;
        mPos = 0;
      end else begin
        mPos++;
      end
    end
    expQ.push_back(e);
    started = 1'b1;
  endtask

  // Advances with fixed inputs until the model reaches a frame position, with a cycle budget.
  task automatic runTo(input int target, input bit en, input logic [1:0] sel);
    int n;
    n = 0;
    while (!(mActive && mPos == target) && n < 2 * FRAME + 4) begin
      applyStimulus(en, sel, 1'b0);
      n++;
    end
    if (!(mActive && mPos == target)) begin
      checks++;
      errors++;
      $display("[TB] FAIL runTo_timeout: position %0d not reached, model at %0d active=%0b", target, mPos, mActive);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (expQ.size() > 0) begin
        checkOutput("pixel", dutOut(), expQ.pop_front());
      end else if (started) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_underflow cycle %0d: got no expectation, required one per cycle", cycle);
      end
    end
  end

  initial begin
    logic [1:0] curSel;
    bit         en;
    checks      = 0;
    errors      = 0;
    cycle       = 0;
    started     = 1'b0;
    mActive     = 1'b0;
    mPos        = 0;
    mPat        = 0;
    reset       = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;

    for (int i = 0; i < 3; i++) applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1);

    // Two frames: bars, with a mid-frame switch to grey that only the second frame honours.
    $display("[TB] bars then deferred grey");
    curSel = 2'd0;
    applyStimulus(1'b1, curSel, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i < FRAME && mPos == HT + 5) curSel = 2'd2;
      applyStimulus(1'b1, curSel, 1'b0);
    end

    $display("[TB] gradient and checker frames");
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b1, 2'd1, 1'b0);
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b1, 2'd3, 1'b0);

    $display("[TB] enable dropped mid line 2, frame drains");
    runTo(2 * HT + 7, 1'b1, 2'd0);
    for (int i = 0; i < FRAME + 20; i++) applyStimulus(1'b0, 2'd0, 1'b0);

    $display("[TB] enable re-raised while draining");
    applyStimulus(1'b1, 2'd3, 1'b0);
    runTo(HT + 3, 1'b1, 2'd3);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 2'd1, 1'b0);
    runTo(FRAME - 1, 1'b1, 2'd1);
    runTo(FRAME / 2, 1'b1, 2'd1);

    $display("[TB] enable dropped exactly on last frame cycle");
    runTo(FRAME - 1, 1'b1, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0);

    $display("[TB] reset mid-line");
    runTo(2 * HT + 4, 1'b1, 2'd2);
    applyStimulus(1'b1, 2'd2, 1'b1);
    applyStimulus(1'b1, 2'd2, 1'b1);
    for (int i = 0; i < FRAME + 10; i++) applyStimulus(1'b1, 2'd0, 1'b0);

    $display("[TB] randomized run");
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en = ~en;
      applyStimulus(en, 2'($urandom_range(0, 3)), ($urandom_range(0, 499) == 0));
    end
    for (int i = 0; i < FRAME + 4; i++) applyStimulus(1'b0, 2'($urandom_range(0, 3)), 1'b0);

    @(posedge clk);
    #2;
    started = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expectations, required 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
